// File: rtl/mfm_field_reader.sv
// MFM field reader: hunts for three 0x4489 syncs, reads the address mark, then
// deserializes the ID or data field with CRC-16-CCITT check and a one-entry output register.
module mfm_field_reader #(
    parameter int          ID_BYTES      = 4,
    parameter int          DATA_BYTES    = 512,
    parameter logic [19:0] TIMEOUT_CELLS = 20'd1000000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic       cell_strobe,
    input  logic       cell_bit,
    output logic       busy,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       done,
    output logic [7:0] mark,
    output logic       crc_ok,
    output logic       timeout,
    output logic       overrun
);
    localparam logic [15:0] SYNC_WORD = 16'h4489;
    localparam logic [15:0] CRC_A1X3  = 16'hCDB4;

    typedef enum logic [2:0] {IDLE, HUNT, SYNC, MARK, PAYLOAD, DONE} state_t;

    state_t      state_q;
    logic [15:0] win_q, win_d;
    logic [1:0]  sync_cnt_q;
    logic [3:0]  cell_cnt_q;
    logic [19:0] tmo_q, tmo_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  byte_sh_q, byte_d;
    logic [15:0] rem_q;
    logic [7:0]  byte_data_q, mark_q;
    logic        byte_valid_q, byte_last_q, done_q, crc_ok_q, timeout_q, overrun_q;
    logic        data_cell, last_cell, tmo_hit, crc_fb;

    always_comb begin
        win_d     = {win_q[14:0], cell_bit};
        byte_d    = {byte_sh_q[6:0], cell_bit};
        crc_fb    = crc_q[15] ^ cell_bit;
        crc_d     = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        tmo_d     = tmo_q + 20'd1;
        tmo_hit   = (tmo_d == TIMEOUT_CELLS);
        // Cells alternate clock/data; the 2nd, 4th, ... 16th carry data.
        data_cell = cell_cnt_q[0];
        last_cell = (cell_cnt_q == 4'd15);
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q      <= IDLE;
            win_q        <= '0;
            sync_cnt_q   <= '0;
            cell_cnt_q   <= '0;
            tmo_q        <= '0;
            crc_q        <= '0;
            byte_sh_q    <= '0;
            rem_q        <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            done_q       <= 1'b0;
            mark_q       <= '0;
            crc_ok_q     <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (byte_ready)
                byte_valid_q <= 1'b0;
            if (cell_strobe)
                win_q <= win_d;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        mark_q     <= '0;
                        crc_ok_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        overrun_q  <= 1'b0;
                        tmo_q      <= '0;
                        sync_cnt_q <= '0;
                        state_q    <= HUNT;
                    end
                end

                HUNT, SYNC, MARK: begin
                    if (cell_strobe) begin
                        tmo_q      <= tmo_d;
                        cell_cnt_q <= cell_cnt_q + 4'd1;
                        if (data_cell) begin
                            byte_sh_q <= byte_d;
                            crc_q     <= crc_d;
                        end
                        // Timeout wins over a sync or mark finishing on this strobe.
                        if (tmo_hit) begin
                            timeout_q <= 1'b1;
                            mark_q    <= '0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else if (state_q == HUNT) begin
                            if (win_d == SYNC_WORD) begin
                                sync_cnt_q <= 2'd1;
                                cell_cnt_q <= '0;
                                state_q    <= SYNC;
                            end
                        end else if (state_q == SYNC) begin
                            if (last_cell) begin
                                if (win_d != SYNC_WORD) begin
                                    sync_cnt_q <= '0;
                                    state_q    <= HUNT;
                                end else if (sync_cnt_q == 2'd2) begin
                                    crc_q   <= CRC_A1X3;
                                    state_q <= MARK;
                                end else begin
                                    sync_cnt_q <= sync_cnt_q + 2'd1;
                                end
                            end
                        end else if (last_cell) begin
                            mark_q <= byte_d;
                            if (byte_d == 8'hFE) begin
                                rem_q   <= 16'(ID_BYTES + 2);
                                state_q <= PAYLOAD;
                            end else if (byte_d == 8'hFB) begin
                                rem_q   <= 16'(DATA_BYTES + 2);
                                state_q <= PAYLOAD;
                            end else begin
                                sync_cnt_q <= '0;
                                state_q    <= HUNT;
                            end
                        end
                    end
                end

                PAYLOAD: begin
                    if (cell_strobe) begin
                        cell_cnt_q <= cell_cnt_q + 4'd1;
                        if (data_cell) begin
                            byte_sh_q <= byte_d;
                            crc_q     <= crc_d;
                        end
                        if (last_cell) begin
                            rem_q <= rem_q - 16'd1;
                            // The two trailing CRC bytes are checked but never offered.
                            if (rem_q > 16'd2) begin
                                if (byte_valid_q && !byte_ready)
                                    overrun_q <= 1'b1;
                                byte_data_q  <= byte_d;
                                byte_last_q  <= (rem_q == 16'd3);
                                byte_valid_q <= 1'b1;
                            end
                            if (rem_q == 16'd1) begin
                                crc_ok_q <= (crc_d == 16'h0000);
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end
                        end
                    end
                end

                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_last_q;
    assign done       = done_q;
    assign mark       = mark_q;
    assign crc_ok     = crc_ok_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;
endmodule

// File: doc/mfm_field_reader.md
# mfm_field_reader

Sequencer that sits after the MFM PLL/decoder path, on the 50 MHz system clock. It takes the recovered MFM cell stream, hunts for the 0x4489 sync word (A1 with missing clock), and counts three consecutive syncs. It then reads the address-mark byte and deserializes the ID or data field. Payload bytes go to a consumer over a valid/ready handshake, and the block reports CRC, timeout and overrun status once per command.

## Interface
- `ID_BYTES`, default 4: payload bytes in an ID field (mark 0xFE).
- `DATA_BYTES`, default 512: payload bytes in a data field (mark 0xFB).
- `TIMEOUT_CELLS`, default 20'd1000000: cell strobes allowed from `start` until a mark is accepted.
- `clk_50` in 1: 50 MHz system clock. One clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle command pulse. Honoured only in IDLE.
- `cell_strobe` in 1: one-cycle pulse per MFM cell, at least 2 cycles apart.
- `cell_bit` in 1: cell value, qualified by `cell_strobe`.
- `busy` out 1: high in every state except IDLE.
- `byte_data` out 8: payload byte.
- `byte_valid` out 1: `byte_data` is valid.
- `byte_last` out 1: qualifies the final payload byte.
- `byte_ready` in 1: consumer accepts when high with `byte_valid`.
- `done` out 1: one-cycle pulse at command end.
- `mark` out 8: address-mark byte read. Holds until next `start`.
- `crc_ok`, `timeout`, `overrun` out 1 each: status. Holds until next `start`.

## Operation
- States: IDLE, HUNT, SYNC, MARK, PAYLOAD, DONE.
- Cell shift register `win[15:0]` shifts left on each `cell_strobe`, with `cell_bit` entering bit 0.
- **IDLE**: on `start`:
  - clear `mark`, `crc_ok`, `timeout`, `overrun` and the timeout counter;
  - go to HUNT.
- **HUNT**: after a shift, if `win`==16'h4489, set sync count to 1, clear cell count, go to SYNC.
- **SYNC**: count cells 0..15. On the 16th cell:
  - if `win`==16'h4489, increment the sync count; on reaching 3, go to MARK with CRC preset to 16'hCDB4 (CRC of A1 A1 A1);
  - otherwise return to HUNT with sync count 0.
- **Byte assembly** (MARK and PAYLOAD):
  - odd cells are clock cells and are ignored; even cells (2nd, 4th, … 16th) are data bits, MSB first;
  - each data bit updates CRC-16-CCITT (poly 0x1021, bit-serial, MSB first).
- **MARK**: after 16 cells, latch `mark`.
  - 0xFE: remaining = `ID_BYTES`+2.
  - 0xFB: remaining = `DATA_BYTES`+2.
  - Any other value: back to HUNT. The timeout counter keeps running.
- **PAYLOAD**: assemble bytes; decrement remaining per byte.
  - The first remaining−2 bytes are offered on the handshake. The last of these has `byte_last`=1.
  - The final 2 bytes are CRC: fed to CRC only, never offered.
  - After the final byte, set `crc_ok` = (CRC==0) and go to DONE.
- **DONE**: pulse `done` for 1 cycle, then go to IDLE.
- **Timeout**:
  - the 20-bit counter increments per `cell_strobe` in HUNT, SYNC and MARK;
  - when it equals `TIMEOUT_CELLS`, set `timeout`=1 and go to DONE. This takes priority over a sync or mark completing on the same strobe.
  - `mark` is 0 in this case.
- **Output register**, single entry:
  - a completed payload byte loads `byte_data`/`byte_last` and sets `byte_valid`;
  - `byte_valid` clears on `byte_ready`;
  - if a byte completes while `byte_valid`=1 and `byte_ready`=0, set sticky `overrun`, overwrite the data, and keep `byte_valid`=1;
  - if `byte_ready` is high in the same cycle a byte completes, the old byte is accepted, the new one loads and there is no overrun.
- `start` while busy is ignored.
- A byte still held when DONE is reached stays valid until accepted.

## Timing
- Reset (synchronous) forces:
  - state IDLE;
  - all outputs 0 (`busy`, `byte_valid`, `byte_last`, `byte_data`, `done`, `mark`, `crc_ok`, `timeout`, `overrun`);
  - `win`, counters and CRC cleared.
- Reset mid-field aborts with no `done`.
- `busy` rises the cycle after `start`.
- State and counter updates occur in the cycle where `cell_strobe`=1. Registered outputs change on the next edge.
- `byte_valid` rises 1 cycle after the strobe of a byte's 16th cell.
- `done` is asserted 1 cycle after the strobe of the last CRC cell.
- `crc_ok`, `mark` and `timeout` are stable when `done` is high.
- Any overlap with the last payload byte is handled by the output-register rules under Operation.

## Test plan
- **Good ID field**:
  - stimulus: `start`, 40 cells of 0x4E-gap MFM, 4489×3, then FE 00 01 02 03 with correct CRC, `byte_ready`=1;
  - required: bytes 00,01,02,03 out with `byte_last` on 03; `done`; `mark`=FE, `crc_ok`=1, `overrun`=0.
- **Corrupted CRC**: same stream with one payload data cell flipped → `done`, `crc_ok`=0, payload bytes still emitted.
- **Broken sync run**:
  - stimulus: 4489, 4489, gap byte, then 4489×3 + FB field;
  - required: the first pair is discarded; the field is read with `mark`=FB and `DATA_BYTES` bytes out.
- **Timeout**: `TIMEOUT_CELLS`=100 with no sync → `done` on the 100th strobe + 1, `timeout`=1, `mark`=0, no `byte_valid`.
- **Overrun**: good ID field with `byte_ready`=0 throughout → `overrun`=1, `byte_data`=03 held valid with `byte_last`=1 after `done`.
- **Reset mid-payload / start ignored while busy**:
  - stimulus: assert `reset` during the 2nd payload byte;
  - required: all outputs 0 next cycle and no `done`; a following `start` reads the next field normally.
  - stimulus: a `start` pulse while busy;
  - required: no state change.
